// File: rtl/tl_a_burst_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tl_a_burst_arbiter                                         |
// | Description : Burst-aware arbiter that merges the TileLink A channels of |
// |               NumHosts hosts onto one device port. A multi-beat message  |
// |               is never interleaved with another host's beats. The host   |
// |               index is carried in the upper device source bits and is    |
// |               used to route D-channel responses back to the right host.  |
// | Options     : TL_A_BURST_ARB_RR_EN defined   -> round-robin priority     |
// |               TL_A_BURST_ARB_RR_EN undefined -> fixed priority, host 0   |
// |               highest                                                    |
// | Ports       : clk_i, rst_ni          clock, async active-low reset       |
// |               host_a_*  (per host)   A channel in, host_a_ready out      |
// |               host_d_*  (per host)   D channel out, host_d_ready in      |
// |               device_a_*             merged A channel, widened source    |
// |               device_d_*             device responses, device_d_ready out|
// |               host_b_valid, host_c_ready, host_e_ready, device_b_ready,  |
// |               device_c_valid         constant B/C/E tie-offs             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tl_a_burst_arbiter #(
  parameter  int NumHosts        = 2,
  parameter  int AddrWidth       = 56,
  parameter  int DataWidth       = 64,
  parameter  int HostSourceWidth = 1,
  parameter  int SinkWidth       = 1,
  parameter  int MaxSize         = 6,
  localparam int IdxWidth        = $clog2(NumHosts),
  localparam int SizeWidth       = $clog2(MaxSize + 1),
  localparam int DevSourceWidth  = HostSourceWidth + IdxWidth,
  localparam int MaskWidth       = DataWidth / 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  // Host A channels
  input  logic [NumHosts-1:0]                       host_a_valid,
  output logic [NumHosts-1:0]                       host_a_ready,
  input  logic [NumHosts-1:0][2:0]                  host_a_opcode,
  input  logic [NumHosts-1:0][2:0]                  host_a_param,
  input  logic [NumHosts-1:0][SizeWidth-1:0]        host_a_size,
  input  logic [NumHosts-1:0][HostSourceWidth-1:0]  host_a_source,
  input  logic [NumHosts-1:0][AddrWidth-1:0]        host_a_address,
  input  logic [NumHosts-1:0][MaskWidth-1:0]        host_a_mask,
  input  logic [NumHosts-1:0]                       host_a_corrupt,
  input  logic [NumHosts-1:0][DataWidth-1:0]        host_a_data,
  // Host D channels
  output logic [NumHosts-1:0]                       host_d_valid,
  input  logic [NumHosts-1:0]                       host_d_ready,
  output logic [NumHosts-1:0][2:0]                  host_d_opcode,
  output logic [NumHosts-1:0][2:0]                  host_d_param,
  output logic [NumHosts-1:0][SizeWidth-1:0]        host_d_size,
  output logic [NumHosts-1:0][HostSourceWidth-1:0]  host_d_source,
  output logic [NumHosts-1:0][SinkWidth-1:0]        host_d_sink,
  output logic [NumHosts-1:0][DataWidth-1:0]        host_d_data,
  output logic [NumHosts-1:0]                       host_d_error,
  // Host B/C/E tie-offs
  output logic [NumHosts-1:0]                       host_b_valid,
  output logic [NumHosts-1:0]                       host_c_ready,
  output logic [NumHosts-1:0]                       host_e_ready,
  // Device A channel
  output logic                                      device_a_valid,
  input  logic                                      device_a_ready,
  output logic [2:0]                                device_a_opcode,
  output logic [2:0]                                device_a_param,
  output logic [SizeWidth-1:0]                      device_a_size,
  output logic [DevSourceWidth-1:0]                 device_a_source,
  output logic [AddrWidth-1:0]                      device_a_address,
  output logic [MaskWidth-1:0]                      device_a_mask,
  output logic                                      device_a_corrupt,
  output logic [DataWidth-1:0]                      device_a_data,
  // Device D channel
  input  logic                                      device_d_valid,
  output logic                                      device_d_ready,
  input  logic [2:0]                                device_d_opcode,
  input  logic [2:0]                                device_d_param,
  input  logic [SizeWidth-1:0]                      device_d_size,
  input  logic [DevSourceWidth-1:0]                 device_d_source,
  input  logic [SinkWidth-1:0]                      device_d_sink,
  input  logic [DataWidth-1:0]                      device_d_data,
  input  logic                                      device_d_error,
  // Device B/C tie-offs
  output logic                                      device_b_ready,
  output logic                                      device_c_valid
);

  localparam int c_beat_lg2 = $clog2(DataWidth / 8);
  // Holds "beats remaining minus one"; one bit minimum when no bursts exist.
  localparam int c_left_w   = (MaxSize > c_beat_lg2) ? (MaxSize - c_beat_lg2) : 1;

  localparam logic [2:0] c_OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] c_OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] c_OP_ARITHMETIC  = 3'd2;
  localparam logic [2:0] c_OP_LOGICAL     = 3'd3;

  localparam logic [0:0] c_S_IDLE   = 1'b0;
  localparam logic [0:0] c_S_LOCKED = 1'b1;

  logic [0:0]          r_state, w_state_next;
  logic [IdxWidth-1:0] r_owner, w_owner_next;
  logic [c_left_w-1:0] r_left, w_left_next, w_first_left;
  logic [IdxWidth-1:0] w_prio, w_winner, w_scan_idx, w_sel;
  logic                w_found, w_data_op, w_multi, w_accept;
  logic [IdxWidth-1:0] w_d_idx;
  logic                w_d_idx_ok;

  // ---------------- priority pointer ----------------
`ifdef TL_A_BURST_ARB_RR_EN
  logic [IdxWidth-1:0] r_prio;

  function automatic logic [IdxWidth-1:0] f_next_idx(input logic [IdxWidth-1:0] idx);
    return IdxWidth'((32'(idx) + 32'd1) % 32'(NumHosts));
  endfunction

  // Advance past whichever host just completed a whole message.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prio <= '0;
    end else if (w_accept) begin
      if (r_state == c_S_IDLE && !w_multi) begin
        r_prio <= f_next_idx(w_winner);
      end else if (r_state == c_S_LOCKED && r_left == '0) begin
        r_prio <= f_next_idx(r_owner);
      end
    end
  end

  assign w_prio = r_prio;
`else
  assign w_prio = '0;
`endif

  // ---------------- winner scan, cyclic from w_prio ----------------
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_scan_idx = '0;
    for (int i = 0; i < NumHosts; i++) begin
      w_scan_idx = IdxWidth'((32'(w_prio) + 32'(i)) % 32'(NumHosts));
      if (!w_found && host_a_valid[w_scan_idx]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx;
      end
    end
  end

  assign w_sel = (r_state == c_S_LOCKED) ? r_owner : w_winner;

  assign device_a_opcode  = host_a_opcode[w_sel];
  assign device_a_param   = host_a_param[w_sel];
  assign device_a_size    = host_a_size[w_sel];
  assign device_a_source  = {w_sel, host_a_source[w_sel]};
  assign device_a_address = host_a_address[w_sel];
  assign device_a_mask    = host_a_mask[w_sel];
  assign device_a_corrupt = host_a_corrupt[w_sel];
  assign device_a_data    = host_a_data[w_sel];

  // Only data-carrying messages larger than one beat span several beats.
  assign w_data_op = (device_a_opcode == c_OP_PUT_FULL)    ||
                     (device_a_opcode == c_OP_PUT_PARTIAL) ||
                     (device_a_opcode == c_OP_ARITHMETIC)  ||
                     (device_a_opcode == c_OP_LOGICAL);
  assign w_multi   = w_data_op && (device_a_size > SizeWidth'(c_beat_lg2));
  // Beats still owed after the first one, minus one (so 0 marks the last).
  assign w_first_left = w_multi ?
      c_left_w'((32'd1 << (32'(device_a_size) - 32'(c_beat_lg2))) - 32'd2) : '0;

  assign w_accept = device_a_valid && device_a_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_S_IDLE;
      r_owner <= '0;
      r_left  <= '0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_left  <= w_left_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_left_next  = r_left;
    case (r_state)
      c_S_LOCKED: begin
        if (w_accept) begin
          if (r_left == '0) begin
            w_state_next = c_S_IDLE;
          end else begin
            w_left_next = r_left - c_left_w'(1);
          end
        end
      end
      default: begin
        if (w_accept && w_multi) begin
          w_state_next = c_S_LOCKED;
          w_owner_next = w_winner;
          w_left_next  = w_first_left;
        end
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    host_a_ready   = '0;
    device_a_valid = 1'b0;
    case (r_state)
      c_S_LOCKED: begin
        device_a_valid        = host_a_valid[r_owner];
        host_a_ready[r_owner] = device_a_ready;
      end
      default: begin
        device_a_valid         = |host_a_valid;
        host_a_ready[w_winner] = device_a_ready && w_found;
      end
    endcase
  end

  // ---------------- D channel routing ----------------
  assign w_d_idx    = device_d_source[HostSourceWidth +: IdxWidth];
  assign w_d_idx_ok = (32'(w_d_idx) < 32'(NumHosts));

  // A response for a nonexistent host is sunk so the device cannot stall.
  always_comb begin
    host_d_valid   = '0;
    device_d_ready = 1'b1;
    if (w_d_idx_ok) begin
      host_d_valid[w_d_idx] = device_d_valid;
      device_d_ready        = host_d_ready[w_d_idx];
    end
  end

  for (genvar g = 0; g < NumHosts; g++) begin : g_host_d
    assign host_d_opcode[g] = device_d_opcode;
    assign host_d_param[g]  = device_d_param;
    assign host_d_size[g]   = device_d_size;
    assign host_d_source[g] = device_d_source[HostSourceWidth-1:0];
    assign host_d_sink[g]   = device_d_sink;
    assign host_d_data[g]   = device_d_data;
    assign host_d_error[g]  = device_d_error;
  end

  assign host_b_valid   = '0;
  assign host_c_ready   = '1;
  assign host_e_ready   = '1;
  assign device_b_ready = 1'b1;
  assign device_c_valid = 1'b0;

  // ---------------- protocol checks ----------------
  for (genvar g = 0; g < NumHosts; g++) begin : g_host_chk
    a_stable_fields: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (host_a_valid[g] && !host_a_ready[g]) |=> (!host_a_valid[g] ||
        $stable({host_a_opcode[g], host_a_param[g], host_a_size[g], host_a_source[g],
                 host_a_address[g], host_a_mask[g], host_a_corrupt[g], host_a_data[g]})));
    a_size_limit: assert property (@(posedge clk_i) disable iff (!rst_ni)
      host_a_valid[g] |-> (32'(host_a_size[g]) <= 32'(MaxSize)));
  end

  a_d_idx_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    device_d_valid |-> w_d_idx_ok);

endmodule
`default_nettype wire
